core_serializer: RTL

CORE_SERIALIZER -- requirements
Module: core_serializer

---
 rtl/core_serializer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/core_serializer.sv
// core_serializer: parallel-to-serial converter with valid/ready handshakes on
// both sides. A Bits-wide word is captured on load accept and emitted as
// Bits/OutBits beats of OutBits each, most- or least-significant beat first.
// The next word may be accepted on the final beat, so there is no bubble between words.
// Optional feature macro: CORE_SERIALIZER_PARITY_EN appends one even-parity beat
// (parity in bit 0, upper bits zero) after the data beats of every word.
module core_serializer #(
    parameter int Bits     = 8,
    parameter int OutBits  = 1,
    parameter bit MsbFirst = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_valid_i,
    output logic               load_ready_o,
    input  logic [Bits-1:0]    data_i,
    output logic               ser_valid_o,
    input  logic               ser_ready_i,
    output logic [OutBits-1:0] ser_data_o,
    output logic               last_o,
    output logic               busy_o
);

    localparam int NData = Bits / OutBits;
`ifdef CORE_SERIALIZER_PARITY_EN
    localparam int NBeats = NData + 1;
`else
    localparam int NBeats = NData;
`endif
    localparam int CntW = (NBeats > 1) ? $clog2(NBeats) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NBeats - 1);

    // A word that does not split into whole beats cannot be serialized.
    if ((Bits % OutBits) != 0) begin : g_bad_width
        $error("core_serializer: Bits (%0d) must be a multiple of OutBits (%0d)", Bits, OutBits);
    end

    // IDLE is encoded as zero so the all-zeros reset lands in IDLE.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [Bits-1:0]   shreg_q, shreg_d;
`ifdef CORE_SERIALIZER_PARITY_EN
    logic              par_q, par_d;
`endif

    logic              is_last;
    logic              xfer;
    logic              accept;
    logic [OutBits-1:0] data_beat;

    // Handshake decode: ready in IDLE, or in SHIFT only as the final beat leaves.
    always_comb begin
        is_last      = (state_q == SHIFT) && (cnt_q == LastCnt);
        xfer         = (state_q == SHIFT) && ser_ready_i;
        load_ready_o = (state_q == IDLE) || (xfer && is_last);
        accept       = load_valid_i && load_ready_o;
    end

    // Output beat: current slice of the shift register (or parity beat), zero in IDLE.
    always_comb begin
        data_beat = MsbFirst ? shreg_q[Bits-1 -: OutBits] : shreg_q[OutBits-1:0];
`ifdef CORE_SERIALIZER_PARITY_EN
        if (cnt_q == CntW'(NData)) begin
            data_beat = OutBits'(par_q);
        end
`endif
        ser_valid_o = (state_q == SHIFT);
        busy_o      = (state_q == SHIFT);
        last_o      = is_last;
        ser_data_o  = (state_q == SHIFT) ? data_beat : '0;
    end

    // Next state: capture on accept (wins over the final-beat exit), shift on each transfer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
`ifdef CORE_SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        if (accept) begin
            state_d = SHIFT;
            cnt_d   = '0;
            shreg_d = data_i;
`ifdef CORE_SERIALIZER_PARITY_EN
            par_d   = ^data_i;
`endif
        end else if (xfer) begin
            if (is_last) begin
                state_d = IDLE;
                cnt_d   = '0;
                shreg_d = '0;
`ifdef CORE_SERIALIZER_PARITY_EN
                par_d   = 1'b0;
`endif
            end else begin
                cnt_d   = cnt_q + CntW'(1);
                shreg_d = MsbFirst ? (shreg_q << OutBits) : (shreg_q >> OutBits);
            end
        end
    end

    // State registers; asynchronous reset aborts any word in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
`ifdef CORE_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
`ifdef CORE_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule
